// File: rtl/bram_sync_dp.sv
`default_nettype none
// ============================================================================
// Module   : bram_sync_dp
// Purpose  : True dual-port synchronous block RAM. Two independent read/write
//            ports share one clock and one array. Reads have one-cycle
//            registered latency, same-port reads during a write are
//            write-first, cross-port reads are read-before-write, and port A
//            wins a same-address write collision.
// Revision : 1.0  initial release
// ============================================================================
module bram_sync_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data_in,
  output logic [DATA_WIDTH-1:0] a_data_out,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data_in,
  output logic [DATA_WIDTH-1:0] b_data_out,
  output logic                  collision
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  // Storage array: never reset so it stays inferable as block RAM.
  logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1] = '{default: '0};

  logic [DATA_WIDTH-1:0] r_a_data_out;
  logic [DATA_WIDTH-1:0] r_b_data_out;
  logic                  r_collision;

  logic w_a_we;
  logic w_b_we;
  logic w_same_addr;

  // Write qualification: writes need enable and a released reset; port B
  // yields to port A when both target the same word.
  assign w_same_addr = (a_addr == b_addr);
  assign w_a_we      = en & rst & a_wr;
  assign w_b_we      = en & rst & b_wr & ~(a_wr & w_same_addr);

  // Array write ports.
  always_ff @(posedge clk) begin
    if (w_a_we) begin
      r_mem[a_addr] <= a_data_in;
    end
    if (w_b_we) begin
      r_mem[b_addr] <= b_data_in;
    end
  end

  // Registered read data and collision flag; the array read samples the
  // pre-edge contents, which gives read-before-write across ports.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_data_out <= '0;
      r_b_data_out <= '0;
      r_collision  <= 1'b0;
    end else if (en) begin
      r_a_data_out <= a_wr ? a_data_in : r_mem[a_addr];
      r_b_data_out <= b_wr ? b_data_in : r_mem[b_addr];
      r_collision  <= a_wr & b_wr & w_same_addr;
    end
  end

  assign a_data_out = r_a_data_out;
  assign b_data_out = r_b_data_out;
  assign collision  = r_collision;

endmodule
`default_nettype wire

// File: tb/tb_bram_sync_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_sync_dp
// Purpose  : Self-checking bench for bram_sync_dp: directed scenarios followed
//            by randomized traffic against an array-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_bram_sync_dp;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          a_wr = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data_in = '0;
  logic [DW-1:0] a_data_out;
  logic          b_wr = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_data_in = '0;
  logic [DW-1:0] b_data_out;
  logic          collision;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] exp_a = '0;
  logic [DW-1:0] exp_b = '0;
  logic          exp_c = 1'b0;

  bram_sync_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .a_wr       (a_wr),
    .a_addr     (a_addr),
    .a_data_in  (a_data_in),
    .a_data_out (a_data_out),
    .b_wr       (b_wr),
    .b_addr     (b_addr),
    .b_data_in  (b_data_in),
    .b_data_out (b_data_out),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".a_out"}, 32'(a_data_out), 32'(exp_a));
    chk({tag, ".b_out"}, 32'(b_data_out), 32'(exp_b));
    chk({tag, ".coll"},  32'(collision),  32'(exp_c));
  endtask

  // Apply one cycle of inputs, advance past the edge, update model, check.
  task automatic step(input logic e,
                      input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input string tag);
    en = e; a_wr = aw; a_addr = aa; a_data_in = ad;
    b_wr = bw; b_addr = ba; b_data_in = bd;
    @(posedge clk);
    #1;
    if (!rst) begin
      exp_a = '0; exp_b = '0; exp_c = 1'b0;
    end else if (e) begin
      exp_a = aw ? ad : m_mem[aa];
      exp_b = bw ? bd : m_mem[ba];
      exp_c = aw && bw && (aa == ba);
      if (bw) m_mem[ba] = bd;
      if (aw) m_mem[aa] = ad;   // A applied last: A wins a same-address clash
    end
    chk_all(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // Reset asserted between edges
    #2 rst = 1'b0;
    #1 chk_all("reset");
    // Write attempt while in reset must be blocked and outputs stay 0
    step(1, 1, 4'd0, 8'h77, 1, 4'd15, 8'h66, "in_reset");
    rst = 1'b1;

    // 1: write-first then read back
    step(1, 1, 4'd2, 8'h55, 0, 4'd0, 8'h00, "t1_wr");
    step(1, 0, 4'd2, 8'h00, 0, 4'd0, 8'h00, "t1_rd");
    // blocked writes left addr 0 and 15 at 0
    step(1, 0, 4'd0, 8'h00, 0, 4'd15, 8'h00, "t1_blocked");

    // 2: overwrite and re-read via B
    step(1, 1, 4'd2, 8'hAA, 0, 4'd0, 8'h00, "t2_w2");
    step(1, 1, 4'd1, 8'hBA, 0, 4'd0, 8'h00, "t2_w1");
    step(1, 1, 4'd6, 8'hBA, 0, 4'd0, 8'h00, "t2_w6");
    step(1, 0, 4'd0, 8'h00, 0, 4'd1, 8'h00, "t2_r1");
    step(1, 0, 4'd0, 8'h00, 0, 4'd2, 8'h00, "t2_r2");
    step(1, 0, 4'd0, 8'h00, 0, 4'd6, 8'h00, "t2_r6");
    chk("t2_r6_const", 32'(b_data_out), 32'h0000_00BA);

    // 3: cross-port read-during-write returns old data
    step(1, 1, 4'd3, 8'h11, 0, 4'd0, 8'h00, "t3_init");
    step(1, 1, 4'd3, 8'h22, 0, 4'd3, 8'h00, "t3_rdw");
    chk("t3_old", 32'(b_data_out), 32'h0000_0011);
    step(1, 0, 4'd0, 8'h00, 0, 4'd3, 8'h00, "t3_new");
    chk("t3_newv", 32'(b_data_out), 32'h0000_0022);

    // 4: write collision, A wins
    step(1, 1, 4'd5, 8'h33, 1, 4'd5, 8'h44, "t4_coll");
    chk("t4_flag", 32'(collision), 32'd1);
    step(1, 0, 4'd5, 8'h00, 0, 4'd5, 8'h00, "t4_rd");
    chk("t4_awins", 32'(b_data_out), 32'h0000_0033);

    // 4b: both write different addresses, boundary addresses
    step(1, 1, 4'd0, 8'h0F, 1, 4'd15, 8'hF0, "t4b_wr");
    step(1, 0, 4'd15, 8'h00, 0, 4'd0, 8'h00, "t4b_rd");

    // 5: enable hold (a_data_out currently 0xF0 from addr 15)
    step(1, 0, 4'd5, 8'h00, 0, 4'd5, 8'h00, "t5_pre");
    for (int i = 0; i < 3; i++) step(0, 1, 4'd5, 8'h99, 1, 4'd7, 8'h98, "t5_hold");
    step(1, 0, 4'd5, 8'h00, 0, 4'd7, 8'h00, "t5_rd");
    chk("t5_kept", 32'(a_data_out), 32'h0000_0033);

    // 6: async reset mid-run, memory preserved
    #3 rst = 1'b0;
    #1 exp_a = '0; exp_b = '0; exp_c = 1'b0;
    chk_all("t6_rst");
    #2 rst = 1'b1;
    step(1, 0, 4'd2, 8'h00, 0, 4'd2, 8'h00, "t6_rd");
    chk("t6_mem", 32'(a_data_out), 32'h0000_00AA);

    // Randomized traffic, addresses biased to a small window for clashes
    for (int i = 0; i < 300; i++) begin
      logic          e, aw, bw;
      logic [AW-1:0] aa, ba;
      e  = ($urandom_range(0, 9) != 0);
      aw = $urandom_range(0, 1) == 1;
      bw = $urandom_range(0, 1) == 1;
      aa = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      ba = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      step(e, aw, aa, DW'($urandom), bw, ba, DW'($urandom), "rand");
    end

    // Final sweep of the whole array through both ports
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, AW'(i), 8'h00, 0, AW'(DEPTH - 1 - i), 8'h00, "sweep");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
